// File: rtl/gerador_teste_circuito.sv
// gerador_teste_circuito
// Self-test driver for a three-input AND-detector (x = a & b & c).
// On an accepted start it sweeps the eight {a,b,c} vectors. Each vector is
// held for SETTLE cycles, and x_in is then sampled in a one-cycle SAMPLE
// state. At the end of the sweep the block reports the captured truth
// table, the mismatch count and the index of the first mismatch.
//
// Parameters
//   SETTLE     cycles each vector is held before its sampling cycle (1..15)
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset; returns to IDLE, all outputs 0
//   start      level-sampled sweep request, honoured only in IDLE or DONE
//   x_in       x output of the circuit under test
//   a, b, c    driven vector, {a,b,c} = vector index
//   busy       high from start acceptance until done rises
//   done       sweep finished, sticky until the next accepted start
//   pass       done with zero mismatches
//   result     captured truth table, bit k = x_in sampled for vector k
//   err_count  number of mismatching vectors (0..8)
//   fail_idx   index of the first mismatching vector, 0 if none
// Build option
//   FAIL_STOP_EN  when defined, the first mismatch ends the sweep at once
module gerador_teste_circuito #(
   parameter int SETTLE = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       x_in,
   output logic       a,
   output logic       b,
   output logic       c,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [7:0] result,
   output logic [3:0] err_count,
   output logic [2:0] fail_idx
);

   typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_SAMPLE, S_DONE} state_t;

   localparam logic [3:0] LP_CNT_LAST = 4'(SETTLE - 1);

   state_t     r_state;
   state_t     w_next;
   logic [2:0] r_vec;
   logic [3:0] r_cnt;
   logic [7:0] r_result;
   logic [3:0] r_err;
   logic [2:0] r_fidx;
   logic       r_busy;
   logic       r_done;
   logic       r_pass;

   logic       w_start_ok;
   logic       w_exp;
   logic       w_mism;
   logic       w_last;
   logic       w_stop;
   logic [3:0] w_err_next;

   assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_DONE));
   assign w_exp      = &r_vec;
   assign w_mism     = (x_in != w_exp);
   assign w_last     = (r_vec == 3'd7);
   assign w_err_next = r_err + {3'b000, w_mism};

`ifdef FAIL_STOP_EN
   // A mismatch terminates the sweep in the same SAMPLE cycle.
   assign w_stop = w_last || w_mism;
`else
   assign w_stop = w_last;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE, S_DONE: if (start)                   w_next = S_DRIVE;
         S_DRIVE:        if (r_cnt == LP_CNT_LAST)    w_next = S_SAMPLE;
         S_SAMPLE:       w_next = w_stop ? S_DONE : S_DRIVE;
         default:        w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vec    <= 3'd0;
         r_cnt    <= 4'd0;
         r_result <= 8'd0;
         r_err    <= 4'd0;
         r_fidx   <= 3'd0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_pass   <= 1'b0;
      end else if (w_start_ok) begin
         r_vec    <= 3'd0;
         r_cnt    <= 4'd0;
         r_result <= 8'd0;
         r_err    <= 4'd0;
         r_fidx   <= 3'd0;
         r_busy   <= 1'b1;
         r_done   <= 1'b0;
         r_pass   <= 1'b0;
      end else begin
         case (r_state)
            S_DRIVE: begin
               r_cnt <= r_cnt + 4'd1;
            end
            S_SAMPLE: begin
               r_result[r_vec] <= x_in;
               if (w_mism) begin
                  r_err <= w_err_next;
                  // Only the first mismatch records its index.
                  if (r_err == 4'd0) r_fidx <= r_vec;
               end
               if (w_stop) begin
                  r_done <= 1'b1;
                  r_busy <= 1'b0;
                  r_pass <= (w_err_next == 4'd0);
               end else begin
                  r_vec <= r_vec + 3'd1;
                  r_cnt <= 4'd0;
               end
            end
            default: ;
         endcase
      end
   end

   assign {a, b, c}  = r_vec;
   assign busy       = r_busy;
   assign done       = r_done;
   assign pass       = r_pass;
   assign result     = r_result;
   assign err_count  = r_err;
   assign fail_idx   = r_fidx;

endmodule

// File: tb/tb_gerador_teste_circuito.sv
module tb_gerador_teste_circuito;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // Two instances: SETTLE = 1 and SETTLE = 3.
   logic       st1 = 1'b0, st3 = 1'b0;
   logic [7:0] tbl1 = 8'h80, tbl3 = 8'h80;
   logic       x1, x3;
   logic       a1, b1, c1, busy1, done1, pass1;
   logic       a3, b3, c3, busy3, done3, pass3;
   logic [7:0] res1, res3;
   logic [3:0] err1, err3;
   logic [2:0] fi1, fi3;

   // Faulty or correct circuit under test: x is a lookup in a truth table.
   assign x1 = tbl1[{a1, b1, c1}];
   assign x3 = tbl3[{a3, b3, c3}];

   gerador_teste_circuito #(.SETTLE(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(st1), .x_in(x1),
      .a(a1), .b(b1), .c(c1), .busy(busy1), .done(done1), .pass(pass1),
      .result(res1), .err_count(err1), .fail_idx(fi1));

   gerador_teste_circuito #(.SETTLE(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .start(st3), .x_in(x3),
      .a(a3), .b(b3), .c(c3), .busy(busy3), .done(done3), .pass(pass3),
      .result(res3), .err_count(err3), .fail_idx(fi3));

   int         cur_sel = 1;
   logic [2:0] m_abc;
   logic       m_busy, m_done, m_pass;
   logic [7:0] m_res;
   logic [3:0] m_err;
   logic [2:0] m_fi;

   always_comb begin
      if (cur_sel == 3) begin
         m_abc = {a3, b3, c3}; m_busy = busy3; m_done = done3; m_pass = pass3;
         m_res = res3; m_err = err3; m_fi = fi3;
      end else begin
         m_abc = {a1, b1, c1}; m_busy = busy1; m_done = done1; m_pass = pass1;
         m_res = res1; m_err = err1; m_fi = fi1;
      end
   end

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference model: walk the eight vectors with the sweep rules.
   logic [7:0] e_res;
   int         e_err, e_fidx, e_lat, e_last;
   logic       e_pass;

   task automatic model(input logic [7:0] tbl, input int s);
      logic expx;
      e_res = 8'h00; e_err = 0; e_fidx = 0; e_lat = 8 * (s + 1); e_last = 7;
      for (int k = 0; k < 8; k++) begin
         e_res[k] = tbl[k];
         expx = (k == 7);
         if (tbl[k] != expx) begin
            if (e_err == 0) e_fidx = k;
            e_err++;
`ifdef FAIL_STOP_EN
            e_lat = (k + 1) * (s + 1);
            e_last = k;
            break;
`endif
         end
      end
      e_pass = (e_err == 0);
   endtask

   task automatic set_start(input logic v);
      if (cur_sel == 3) st3 = v; else st1 = v;
   endtask

   task automatic sweep(input int sel, input logic [7:0] tbl);
      int  s;
      bit  seen;
      int  n;
      cur_sel = sel;
      s = (sel == 3) ? 3 : 1;
      if (sel == 3) tbl3 = tbl; else tbl1 = tbl;
      model(tbl, s);
      @(negedge clk);
      set_start(1'b1);
      @(posedge clk);        // E0
      @(negedge clk);
      set_start(1'b0);
      chk("busy_at_E0", m_busy, 1);
      chk("done_at_E0", m_done, 0);
      chk("abc_at_E0", m_abc, 0);
      seen = 0;
      n = 0;
      for (int i = 1; i <= 200 && !seen; i++) begin
         @(posedge clk);
         @(negedge clk);
         n = i;
         if (m_done) seen = 1;
         else chk("abc_vec", m_abc, 32'((i / (s + 1)) % 8));
      end
      if (!seen) begin
         chk("done_timeout", 0, 1);
      end else begin
         chk("done_latency", n, e_lat);
         chk("busy_at_done", m_busy, 0);
         chk("result", m_res, e_res);
         chk("err_count", m_err, e_err);
         chk("fail_idx", m_fi, e_fidx);
         chk("pass", m_pass, e_pass);
         chk("abc_hold", m_abc, e_last);
      end
   endtask

   initial begin
      #2;
      cur_sel = 1;
      #1 chk("reset_outs1", {m_abc, m_busy, m_done, m_pass, m_res, m_err, m_fi}, 0);
      cur_sel = 3;
      #1 chk("reset_outs3", {m_abc, m_busy, m_done, m_pass, m_res, m_err, m_fi}, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed: correct model, stuck-at-0, stuck-at-1, SETTLE = 3.
      sweep(1, 8'h80);
      sweep(1, 8'h00);
      sweep(1, 8'hFF);
      sweep(3, 8'h80);
      sweep(3, 8'hFF);

      // Randomized faulty truth tables; restart straight from DONE.
      for (int r = 0; r < 8; r++) begin
         logic [7:0] t;
         t = 8'($urandom);
         if ($urandom_range(0, 3) == 0) t = 8'h80;
         sweep((r % 2 == 0) ? 1 : 3, t);
      end

      // Start during a sweep is ignored; reset mid-sweep clears everything.
      cur_sel = 1;
      tbl1 = 8'h80;
      @(negedge clk);
      st1 = 1'b1;
      @(posedge clk);        // E0
      @(negedge clk);
      st1 = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      st1 = 1'b1;            // sampled at E0+5
      @(posedge clk);
      @(negedge clk);
      st1 = 1'b0;
      repeat (3) @(posedge clk);   // E0+8
      @(negedge clk);
      chk("no_restart_abc", m_abc, 4);
      chk("no_restart_busy", m_busy, 1);
      @(posedge clk);        // E0+9
      #1 rst_n = 1'b0;
      #1 chk("midreset_outs1", {m_abc, m_busy, m_done, m_pass, m_res, m_err, m_fi}, 0);
      @(posedge clk);
      @(negedge clk);
      chk("midreset_idle", {m_abc, m_busy, m_done}, 0);
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("idle_no_start", {m_abc, m_busy, m_done}, 0);
      sweep(1, 8'h80);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
